// File: rtl/kj_count_l7_if.sv
// rtl/kj_count_l7_if.sv - control/status bundle between MAC sequencer and kj counter
interface kj_count_l7_if #(
  parameter int J_W = 4
);
  logic [2:0]     u;
  logic           start;
  logic           en;
  logic           R_zero;
  logic [1:0]     k;
  logic [J_W-1:0] j;
  logic           k_zero;
  logic           j_zero;
  logic           busy;
  logic           done;

  modport master (
    output u, start, en, R_zero,
    input  k, j, k_zero, j_zero, busy, done
  );

  modport slave (
    input  u, start, en, R_zero,
    output k, j, k_zero, j_zero, busy, done
  );
endinterface

// File: rtl/kj_count_l7.sv
// rtl/kj_count_l7.sv - nested kernel-column (k) / output-position (j) counter with pass tracking
module kj_count_l7 #(
  parameter int J_W   = 4,
  parameter int P_MAX = 5
) (
  input logic         clk,
  input logic         rst,
  kj_count_l7_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [2:0]     u_q, u_d;
  logic [1:0]     k_q, k_d, k_max;
  logic [J_W-1:0] j_q, j_d, j_max;
  logic [3:0]     p_q, p_d;
  logic           done_q, done_d;
  logic           k_hit, j_hit, last_pass;

  always_comb begin
    k_max = 2'd0;
    j_max = '0;
    case (u_q)
      3'd0:    begin k_max = 2'd2; j_max = J_W'(13); end
      3'd1:    begin k_max = 2'd0; j_max = J_W'(13); end
      3'd2:    begin k_max = 2'd0; j_max = J_W'(6);  end
      3'd3:    begin k_max = 2'd2; j_max = J_W'(6);  end
      3'd4:    begin k_max = 2'd2; j_max = J_W'(6);  end
      3'd5:    begin k_max = 2'd0; j_max = J_W'(6);  end
      default: begin k_max = 2'd0; j_max = '0;       end
    endcase
  end

  assign k_hit     = (state_q == RUN) && bus.en && (k_q == k_max);
  assign j_hit     = k_hit && (j_q == j_max);
  assign last_pass = (p_q == 4'(P_MAX - 1));

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    k_d     = k_q;
    j_d     = j_q;
    p_d     = p_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          u_d     = bus.u;
          k_d     = 2'd0;
          j_d     = '0;
          p_d     = 4'd0;
        end
      end
      RUN: begin
        // completion beats a same-cycle R_zero; both leave k/j at zero
        if (j_hit && last_pass) begin
          state_d = IDLE;
          k_d     = 2'd0;
          j_d     = '0;
          p_d     = 4'd0;
          done_d  = 1'b1;
        end else if (bus.R_zero) begin
          k_d = 2'd0;
          j_d = '0;
        end else if (bus.en) begin
          if (k_hit) begin
            k_d = 2'd0;
            if (j_hit) begin
              j_d = '0;
              p_d = p_q + 4'd1;
            end else begin
              j_d = j_q + J_W'(1);
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      u_q     <= 3'd0;
      k_q     <= 2'd0;
      j_q     <= '0;
      p_q     <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      k_q     <= k_d;
      j_q     <= j_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign bus.k      = k_q;
  assign bus.j      = j_q;
  assign bus.k_zero = k_hit;
  assign bus.j_zero = j_hit;
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
endmodule

// File: tb/tb_kj_count_l7.sv
// tb/tb_kj_count_l7.sv - vector table, corner sequences and random run against a linear-index model
module tb_kj_count_l7;
  localparam int J_W   = 4;
  localparam int P_MAX = 5;

  logic clk;
  logic rst;
  kj_count_l7_if #(.J_W(J_W)) bus_if ();

  kj_count_l7 #(.J_W(J_W), .P_MAX(P_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int kmax_t [8] = '{2, 0, 0, 2, 2, 0, 0, 0};
  int jmax_t [8] = '{13, 13, 6, 6, 6, 6, 0, 0};

  // model: position within a pass as one linear index; k/j derived by div/mod
  bit m_run  = 0;
  int m_mode = 0;
  int m_idx  = 0;
  int m_p    = 0;
  bit m_done = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] u;
    logic       en;
    logic       rz;
    int         k;
    int         j;
    logic       kz;
    logic       jz;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] uu,
                       input logic e, input logic rz);
    @(negedge clk);
    rst           = r;
    bus_if.start  = s;
    bus_if.u      = uu;
    bus_if.en     = e;
    bus_if.R_zero = rz;
    #1;
  endtask

  task automatic check_model();
    int kk, nn;
    kk = kmax_t[m_mode] + 1;
    nn = kk * (jmax_t[m_mode] + 1);
    chk("m_k", 32'(bus_if.k), 32'(m_idx % kk));
    chk("m_j", 32'(bus_if.j), 32'(m_idx / kk));
    chk("m_k_zero", 32'(bus_if.k_zero), 32'(m_run && bus_if.en && (m_idx % kk == kk - 1)));
    chk("m_j_zero", 32'(bus_if.j_zero), 32'(m_run && bus_if.en && (m_idx == nn - 1)));
    chk("m_busy", 32'(bus_if.busy), 32'(m_run));
    chk("m_done", 32'(bus_if.done), 32'(m_done));
  endtask

  task automatic tick();
    int kk, nn;
    @(posedge clk);
    kk = kmax_t[m_mode] + 1;
    nn = kk * (jmax_t[m_mode] + 1);
    if (!rst) begin
      m_run = 0; m_mode = 0; m_idx = 0; m_p = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (bus_if.start) begin
          m_run = 1; m_mode = int'(bus_if.u); m_idx = 0; m_p = 0;
        end
      end else if (bus_if.en && m_idx == nn - 1 && m_p == P_MAX - 1) begin
        m_run = 0; m_idx = 0; m_p = 0; m_done = 1;
      end else if (bus_if.R_zero) begin
        m_idx = 0;
      end else if (bus_if.en) begin
        m_idx++;
        if (m_idx == nn) begin
          m_idx = 0;
          m_p++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [2:0] uu,
                      input logic e, input logic rz);
    drive(r, s, uu, e, rz);
    check_model();
    tick();
  endtask

  initial begin
    int kzc, jzc, n;
    rst = 1'b0; bus_if.start = 1'b0; bus_if.u = 3'd0; bus_if.en = 1'b0; bus_if.R_zero = 1'b0;

    //            rst start u  en rz  k  j  kz jz busy done
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

    drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].start, tbl[i].u, tbl[i].en, tbl[i].rz);
      chk($sformatf("v%0d_k", i), 32'(bus_if.k), 32'(tbl[i].k));
      chk($sformatf("v%0d_j", i), 32'(bus_if.j), 32'(tbl[i].j));
      chk($sformatf("v%0d_kz", i), 32'(bus_if.k_zero), 32'(tbl[i].kz));
      chk($sformatf("v%0d_jz", i), 32'(bus_if.j_zero), 32'(tbl[i].jz));
      chk($sformatf("v%0d_busy", i), 32'(bus_if.busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_done", i), 32'(bus_if.done), 32'(tbl[i].done));
      tick();
    end

    // u=1 continuous: 70 en cycles, done on the following cycle
    step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    kzc = 0; jzc = 0;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      check_model();
      kzc += int'(bus_if.k_zero);
      jzc += int'(bus_if.j_zero);
      tick();
    end
    chk("u1_kzero_count", 32'(kzc), 32'd70);
    chk("u1_jzero_count", 32'(jzc), 32'd5);
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("u1_done", 32'(bus_if.done), 32'd1);
    chk("u1_busy_low", 32'(bus_if.busy), 32'd0);
    tick();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("u1_done_one_cycle", 32'(bus_if.done), 32'd0);
    tick();

    // u=0: R_zero with en at k=2,j=4, then pass count must be intact
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("rz_pre_k", 32'(bus_if.k), 32'd2);
    chk("rz_pre_j", 32'(bus_if.j), 32'd4);
    tick();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("rz_post_k", 32'(bus_if.k), 32'd0);
    chk("rz_post_j", 32'(bus_if.j), 32'd0);
    tick();
    for (n = 0; n < 300; n++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      check_model();
      if (bus_if.done) begin
        tick();
        break;
      end
      tick();
    end
    chk("rz_p_kept_len", 32'(n), 32'd210);

    // u=2: final j_zero coincident with R_zero still completes
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    chk("fin_rz_jzero", 32'(bus_if.j_zero), 32'd1);
    tick();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("fin_rz_done", 32'(bus_if.done), 32'd1);
    chk("fin_rz_busy", 32'(bus_if.busy), 32'd0);
    chk("fin_rz_j", 32'(bus_if.j), 32'd0);
    tick();

    // mid-run reset at k=1,j=9, then a clean u=2 run
    step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 28; i++) step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("rst_pre_k", 32'(bus_if.k), 32'd1);
    chk("rst_pre_j", 32'(bus_if.j), 32'd9);
    tick();
    drive(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_no_done", 32'(bus_if.done), 32'd0);
    chk("rst_k", 32'(bus_if.k), 32'd0);
    chk("rst_j", 32'(bus_if.j), 32'd0);
    tick();
    step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    for (n = 0; n < 100; n++) begin
      drive(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
      check_model();
      if (bus_if.done) begin
        tick();
        break;
      end
      tick();
    end
    chk("rst_rerun_len", 32'(n), 32'd35);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 60) != 0, ($urandom % 6) == 0, 3'($urandom % 8),
           ($urandom % 4) != 0, ($urandom % 50) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
